// File: rtl/updown_seqdet_if.sv
// Bus bundle for updown_seqdet: counter controls, serial detector inputs and
// all registered/decoded outputs. The DUT uses the slave modport.
interface updown_seqdet_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic [7:0]       seg;
  logic             det;
  logic [7:0]       hits;

  modport master (
    output en, down, load, load_val, ser_in, ser_valid,
    input  count, wrap, seg, det, hits
  );

  modport slave (
    input  en, down, load, load_val, ser_in, ser_valid,
    output count, wrap, seg, det, hits
  );
endinterface

// File: rtl/updown_seqdet.sv
// Modulo-N up/down counter with 7-seg decode, plus a serial pattern detector
// with a saturating hit counter. Define UPDOWN_SEQDET_OVERLAP_EN for overlapping matches.
module updown_seqdet #(
  parameter int          WIDTH       = 4,
  parameter int          MODULUS     = 16,
  parameter int          SEQ_LEN     = 3,
  parameter int unsigned SEQ_PATTERN = 'b111
) (
  input logic            clk_2,
  input logic            reset,
  updown_seqdet_if.slave bus
);

  localparam logic [WIDTH-1:0]   MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam int                 FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SEQ_LEN);
  localparam logic [SEQ_LEN-1:0] PATTERN   = SEQ_PATTERN[SEQ_LEN-1:0];

  logic [WIDTH-1:0]   count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [SEQ_LEN-1:0] sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_q;
  logic [7:0]         hits_q;
  logic [SEQ_LEN-1:0] sr_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;
  logic [3:0]         nibble;
  logic [7:0]         seg;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      if (32'(bus.load_val) >= MODULUS)
        count_d = MAX_COUNT;
      else
        count_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.down) begin
        if (count_q == '0) begin
          count_d = MAX_COUNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end else begin
        if (count_q == MAX_COUNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Match is judged on the post-shift window, so det lands one cycle after the completing bit.
  always_comb begin
    sr_shift = {sr_q[SEQ_LEN-2:0], bus.ser_in};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match    = bus.ser_valid && (sr_shift == PATTERN) && (fill_inc == FILL_FULL);
    sr_d     = sr_q;
    fill_d   = fill_q;
    if (bus.ser_valid) begin
      sr_d   = sr_shift;
      fill_d = fill_inc;
`ifdef UPDOWN_SEQDET_OVERLAP_EN
`else
      if (match)
        fill_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      hits_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
      det_q  <= match;
      if (match && hits_q != 8'hFF)
        hits_q <= hits_q + 8'd1;
    end
  end

  generate
    if (WIDTH >= 4) begin : g_nib_wide
      assign nibble = count_q[3:0];
    end else begin : g_nib_narrow
      assign nibble = {{(4-WIDTH){1'b0}}, count_q};
    end
  endgenerate

  always_comb begin
    seg = 8'h00;
    case (nibble)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg;
  assign bus.det   = det_q;
  assign bus.hits  = hits_q;

endmodule

// File: tb/tb_updown_seqdet.sv
// Randomised and directed bench for updown_seqdet: a default instance (mod 16,
// pattern 111) and a mod-10 / pattern 101 instance, both against a queue-based model.
module tb_updown_seqdet;

  typedef bit bitq_t[$];

  logic clk_2 = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  updown_seqdet_if #(.WIDTH(4)) bus_a ();
  updown_seqdet_if #(.WIDTH(4)) bus_b ();

  updown_seqdet #(.WIDTH(4), .MODULUS(16), .SEQ_LEN(3), .SEQ_PATTERN('b111)) dut_a (
    .clk_2(clk_2), .reset(reset), .bus(bus_a)
  );
  updown_seqdet #(.WIDTH(4), .MODULUS(10), .SEQ_LEN(3), .SEQ_PATTERN('b101)) dut_b (
    .clk_2(clk_2), .reset(reset), .bus(bus_b)
  );

  always #5 clk_2 = ~clk_2;

  localparam int MODS [2] = '{16, 10};
  localparam int PATS [2] = '{7, 5};

  int    m_cnt  [2];
  int    m_wrap [2];
  int    m_det  [2];
  int    m_hits [2];
  bitq_t hist0, hist1;
  int    seg_table [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                            'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int tailValue(input bitq_t q);
    int v = 0;
    for (int k = q.size() - 3; k < q.size(); k++) v = (v << 1) | int'(q[k]);
    return v;
  endfunction

  // Behavioural reference: arithmetic modulo counter, and a history of
  // valid bits since reset / last non-overlapping match.
  task automatic modelStep(input int i, input bit rst, input bit en, input bit down,
                           input bit load, input int lv, input bit si, input bit sv);
    bitq_t h;
    bit    m;
    h = (i == 0) ? hist0 : hist1;
    if (rst) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_det[i] = 0; m_hits[i] = 0;
      h.delete();
    end else begin
      m_wrap[i] = 0;
      if (load) begin
        m_cnt[i] = (lv >= MODS[i]) ? MODS[i] - 1 : lv;
      end else if (en) begin
        if (down) begin
          if (m_cnt[i] == 0) m_wrap[i] = 1;
          m_cnt[i] = (m_cnt[i] + MODS[i] - 1) % MODS[i];
        end else begin
          if (m_cnt[i] == MODS[i] - 1) m_wrap[i] = 1;
          m_cnt[i] = (m_cnt[i] + 1) % MODS[i];
        end
      end
      m = 1'b0;
      if (sv) begin
        h.push_back(si);
        m = (h.size() >= 3) && (tailValue(h) == PATS[i]);
`ifdef UPDOWN_SEQDET_OVERLAP_EN
        if (h.size() > 8) void'(h.pop_front());
`else
        if (m) h.delete();
`endif
      end
      m_det[i] = m;
      if (m && m_hits[i] < 255) m_hits[i]++;
    end
    if (i == 0) hist0 = h; else hist1 = h;
  endtask

  task automatic checkAll();
    checkOutput("a.count", 32'(bus_a.count), m_cnt[0]);
    checkOutput("a.wrap",  32'(bus_a.wrap),  m_wrap[0]);
    checkOutput("a.seg",   32'(bus_a.seg),   seg_table[m_cnt[0]]);
    checkOutput("a.det",   32'(bus_a.det),   m_det[0]);
    checkOutput("a.hits",  32'(bus_a.hits),  m_hits[0]);
    checkOutput("b.count", 32'(bus_b.count), m_cnt[1]);
    checkOutput("b.wrap",  32'(bus_b.wrap),  m_wrap[1]);
    checkOutput("b.seg",   32'(bus_b.seg),   seg_table[m_cnt[1]]);
    checkOutput("b.det",   32'(bus_b.det),   m_det[1]);
    checkOutput("b.hits",  32'(bus_b.hits),  m_hits[1]);
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit down, input bit load,
                               input int lv, input bit si, input bit sv);
    reset          = rst;
    bus_a.en       = en;   bus_b.en       = en;
    bus_a.down     = down; bus_b.down     = down;
    bus_a.load     = load; bus_b.load     = load;
    bus_a.load_val = 4'(lv); bus_b.load_val = 4'(lv);
    bus_a.ser_in   = si;   bus_b.ser_in   = si;
    bus_a.ser_valid = sv;  bus_b.ser_valid = sv;
    @(posedge clk_2);
    modelStep(0, rst, en, down, load, lv, si, sv);
    modelStep(1, rst, en, down, load, lv, si, sv);
    #1;
    checkAll();
  endtask

  task automatic serialBit(input bit si);
    applyStimulus(0, 0, 0, 0, 0, si, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // up count through a full wrap
    repeat (17) applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // down from reset, then out-of-range load clamps
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 12, 0, 0);

    // load beats en at terminal count; reset beats load
    applyStimulus(0, 0, 0, 1, 15, 0, 0);
    applyStimulus(0, 1, 0, 1, 5, 0, 0);
    applyStimulus(1, 1, 0, 1, 7, 0, 0);

    // 0,1,1,1,1 with valid dropping between bits
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    foreach (PATS[k]) begin end
    serialBit(0); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (4) begin
      serialBit(1); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end

    // partial 101 broken by reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    serialBit(1); serialBit(0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    serialBit(1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // hit counter saturation
    repeat (300) begin
      serialBit(1); serialBit(0); serialBit(1);
    end

    // reset mid 111 pattern
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    serialBit(1); serialBit(1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    repeat (4) serialBit(1);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0,
                    1'($urandom),
                    $urandom_range(0, 15) == 0,
                    int'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0,
                    1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
